usb_xact_engine: RTL and testbench
==================================

Name: usb_xact_engine

Overview:
- Parametrised host-side USB transaction engine; successor to the fixed-width IN/OUT protocol controller.
- Sits between the read/write layer and the packet encoder/decoder.
- Runs complete IN and OUT transactions: token, data, then handshake.
- Tracks a per-endpoint DATA0/DATA1 toggle, handles STALL, and uses a configurable timeout and retry limit.

Parameters:
- DATA_BYTES, 8, payload bytes per data packet; DATA_W = 8*DATA_BYTES.
- NUM_ENDP, 16, number of endpoints with a tracked toggle bit (2..16).
- MAX_RETRIES, 3, retries allowed after the first attempt before giving up.
- TIMEOUT_LEN, 255, cycles to wait for a decoder packet before declaring a timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- xact_dir  in  1  0 = OUT, 1 = IN; captured at start
- addr  in  7  device address; captured at start
- endp  in  4  endpoint; captured at start
- wr_data  in  DATA_W  OUT payload; captured at start
- toggle_clr  in  1  clears every toggle to DATA0; ignored unless IDLE
- rd_data  out  DATA_W  IN payload
- rd_valid  out  1  one-cycle pulse: rd_data is valid
- done  out  1  one-cycle pulse at end of transaction
- status  out  2  0 OK, 1 RETRY_LIMIT, 2 STALL; held until next start
- busy  out  1  high whenever state is not IDLE
- tx_pid  out  8  PID byte to the encoder
- tx_addr  out  7  token address field
- tx_endp  out  4  token endpoint field
- tx_data  out  DATA_W  data payload to the encoder
- tx_valid  out  1  packet request to the encoder
- tx_ready  in  1  encoder accepts the packet while tx_valid && tx_ready
- rx_pid  in  8  PID of the decoded packet
- rx_data  in  DATA_W  decoded payload
- rx_valid  in  1  one-cycle pulse: decoded packet present
- rx_corrupt  in  1  qualifies rx_valid: CRC or PID-check failure
- rx_en  out  1  decoder enable; high only in WAIT_HS and WAIT_DATA

Behaviour:
- Reset values:
  - State IDLE; all toggles 0; retry count 0; timeout counter 0.
  - All outputs 0.
  - Reset mid-transaction aborts without a done pulse.
- PID encodings: OUT E1, IN 69, DATA0 C3, DATA1 4B, ACK D2, NAK 5A, STALL 1E.
- Tx handshake:
  - tx_valid and all tx_* fields stay stable until the cycle where tx_ready=1.
  - The state advances on the cycle after acceptance.
- States:
  - IDLE: on start, capture the request, clear the retry count, go to TOKEN.
  - TOKEN: tx_pid = OUT or IN with the captured addr/endp. Accepted → DATA_TX (OUT) or WAIT_DATA (IN).
  - DATA_TX: tx_pid = DATA0/DATA1 per toggle[endp], tx_data = captured wr_data. Accepted → WAIT_HS.
  - WAIT_HS: first of these wins:
    - rx_valid && !rx_corrupt && ACK → flip toggle, status OK, DONE.
    - rx_valid && !rx_corrupt && STALL → status STALL, DONE.
    - NAK, corrupt, any other PID, or timeout → RETRY.
  - WAIT_DATA:
    - Valid DATAx matching the toggle → latch rx_data, SEND_HS, mark good.
    - Valid DATAx with mismatched toggle → SEND_HS, mark discard.
    - Valid STALL → status STALL, DONE.
    - NAK, corrupt, or timeout → RETRY. No handshake is sent for corrupt packets.
  - SEND_HS: tx_pid = ACK. Accepted:
    - good → flip toggle, pulse rd_valid, status OK, DONE.
    - discard → RETRY.
  - RETRY:
    - If retry count == MAX_RETRIES → status RETRY_LIMIT, DONE.
    - Otherwise increment the count and go to TOKEN (the full transaction is resent).
  - DONE: done=1 for one cycle → IDLE.
- Timeout:
  - Counter runs only in WAIT_HS and WAIT_DATA and clears in every other state.
  - Fires when the count reaches TIMEOUT_LEN.
  - An rx_valid in the same cycle as the timeout takes priority.
- Boundaries:
  - start outside IDLE is ignored.
  - toggle_clr together with start in IDLE: the clear applies first and the new transaction uses DATA0.
  - An endp value >= NUM_ENDP uses the toggle at index endp mod NUM_ENDP.
  - rx_valid outside the wait states is ignored.
  - Retry count is $clog2(MAX_RETRIES+1) bits wide and saturates; it never wraps.

Decomposition:
- usb_pkg holds:
  - PID constants.
  - The xact_state_t enum: IDLE, TOKEN, DATA_TX, WAIT_HS, WAIT_DATA, SEND_HS, RETRY, DONE.
  - The status_t enum.
- One sub-module, xact_timer, parameterised by TIMEOUT_LEN, with inputs en and clr and output expired.

Test Plan:
- OUT to addr 0x05, endp 1, wr_data 0x1122334455667788; encoder ready; device replies ACK → tx PIDs E1 then C3; done with status 0; toggle[1]=1; a second OUT sends 4B.
- IN to endp 2; device sends DATA0 carrying 0xDEADBEEF00000000 → ACK (D2) sent; rd_valid pulses with that value; status 0; toggle[2]=1.
- OUT with the device NAKing every attempt, MAX_RETRIES=3 → exactly 4 E1/C3 pairs sent; status 1; toggle unchanged.
- IN with no decoder response → timeout after 255 cycles in WAIT_DATA, then retry; a corrupt DATA0 on the second attempt is not handshaken; a good DATA0 on the third attempt → status 0.
- IN after a lost ACK (toggle=1, device resends DATA0) → ACK sent, rd_valid stays low, retry; the following DATA1 is delivered.
- OUT answered with STALL → status 2 with no retry; assert rst during the next WAIT_HS → busy=0, no done pulse, all toggles 0.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - PID constants, state and status types for the USB transaction engine.
package usb_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  typedef enum logic [2:0] {
    IDLE,
    TOKEN,
    DATA_TX,
    WAIT_HS,
    WAIT_DATA,
    SEND_HS,
    RETRY,
    DONE
  } xact_state_t;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_RETRY_LIMIT = 2'd1,
    ST_STALL       = 2'd2
  } status_t;

  function automatic logic [7:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/xact_timer.sv
// rtl/xact_timer.sv - response timeout counter; counts while enabled, expires at TIMEOUT_LEN.
module xact_timer #(
  parameter int TIMEOUT_LEN = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_LEN < 2) ? 1 : $clog2(TIMEOUT_LEN + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = (r_cnt == CW'(TIMEOUT_LEN));

endmodule

// File: rtl/usb_xact_engine.sv
// rtl/usb_xact_engine.sv - host-side USB IN/OUT transaction engine with per-endpoint
// data toggles, STALL handling, response timeout and bounded retries.
module usb_xact_engine
  import usb_pkg::*;
#(
  parameter  int DATA_BYTES  = 8,
  parameter  int NUM_ENDP    = 16,
  parameter  int MAX_RETRIES = 3,
  parameter  int TIMEOUT_LEN = 255,
  localparam int DATA_W      = 8 * DATA_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              xact_dir,
  input  logic [6:0]        addr,
  input  logic [3:0]        endp,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              toggle_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic [1:0]        status,
  output logic              busy,
  output logic [7:0]        tx_pid,
  output logic [6:0]        tx_addr,
  output logic [3:0]        tx_endp,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_pid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_corrupt,
  output logic              rx_en
);

  localparam int IDX_W = (NUM_ENDP < 2) ? 1 : $clog2(NUM_ENDP);
  localparam int RW    = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  xact_state_t       r_state, w_next;
  logic              r_dir;
  logic [6:0]        r_addr;
  logic [3:0]        r_endp;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rd_data;
  logic [NUM_ENDP-1:0] r_toggle;
  logic [RW-1:0]     r_retry;
  logic              r_good;
  logic              r_rd_valid;
  status_t           r_status;

  logic [IDX_W-1:0]  w_tidx;
  logic              w_tog;
  logic              w_wait;
  logic              w_expired;
  logic              w_capture;
  logic              w_flip;
  logic              w_set_status;
  status_t           w_status_val;
  logic              w_mark;
  logic              w_mark_val;
  logic              w_latch_rd;
  logic              w_rd_pulse;
  logic              w_retry_inc;

  assign w_tidx = IDX_W'(32'(r_endp) % NUM_ENDP);
  assign w_tog  = r_toggle[w_tidx];
  assign w_wait = (r_state == WAIT_HS) || (r_state == WAIT_DATA);

  xact_timer #(.TIMEOUT_LEN(TIMEOUT_LEN)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (w_wait),
    .clr     (~w_wait),
    .expired (w_expired)
  );

  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_flip       = 1'b0;
    w_set_status = 1'b0;
    w_status_val = ST_OK;
    w_mark       = 1'b0;
    w_mark_val   = 1'b0;
    w_latch_rd   = 1'b0;
    w_rd_pulse   = 1'b0;
    w_retry_inc  = 1'b0;
    tx_valid     = 1'b0;
    tx_pid       = 8'h00;
    tx_addr      = 7'h00;
    tx_endp      = 4'h0;
    tx_data      = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = TOKEN;
        end
      end
      TOKEN: begin
        tx_valid = 1'b1;
        tx_pid   = r_dir ? PID_IN : PID_OUT;
        tx_addr  = r_addr;
        tx_endp  = r_endp;
        if (tx_ready) w_next = r_dir ? WAIT_DATA : DATA_TX;
      end
      DATA_TX: begin
        tx_valid = 1'b1;
        tx_pid   = data_pid(w_tog);
        tx_data  = r_wr_data;
        if (tx_ready) w_next = WAIT_HS;
      end
      WAIT_HS: begin
        // a packet arriving on the timeout cycle is still honoured
        if (rx_valid) begin
          if (!rx_corrupt && rx_pid == PID_ACK) begin
            w_flip       = 1'b1;
            w_set_status = 1'b1;
            w_status_val = ST_OK;
            w_next       = DONE;
          end else if (!rx_corrupt && rx_pid == PID_STALL) begin
            w_set_status = 1'b1;
            w_status_val = ST_STALL;
            w_next       = DONE;
          end else begin
            w_next = RETRY;
          end
        end else if (w_expired) begin
          w_next = RETRY;
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          if (rx_corrupt || rx_pid == PID_NAK) begin
            w_next = RETRY;
          end else if (rx_pid == PID_DATA0 || rx_pid == PID_DATA1) begin
            // a toggle mismatch is a resend of data we already have: ACK it, drop it
            w_mark     = 1'b1;
            w_mark_val = (rx_pid == data_pid(w_tog));
            w_latch_rd = w_mark_val;
            w_next     = SEND_HS;
          end else if (rx_pid == PID_STALL) begin
            w_set_status = 1'b1;
            w_status_val = ST_STALL;
            w_next       = DONE;
          end else begin
            w_next = RETRY;
          end
        end else if (w_expired) begin
          w_next = RETRY;
        end
      end
      SEND_HS: begin
        tx_valid = 1'b1;
        tx_pid   = PID_ACK;
        if (tx_ready) begin
          if (r_good) begin
            w_flip       = 1'b1;
            w_rd_pulse   = 1'b1;
            w_set_status = 1'b1;
            w_status_val = ST_OK;
            w_next       = DONE;
          end else begin
            w_next = RETRY;
          end
        end
      end
      RETRY: begin
        if (r_retry == RW'(MAX_RETRIES)) begin
          w_set_status = 1'b1;
          w_status_val = ST_RETRY_LIMIT;
          w_next       = DONE;
        end else begin
          w_retry_inc = 1'b1;
          w_next      = TOKEN;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_addr     <= '0;
      r_endp     <= '0;
      r_wr_data  <= '0;
      r_rd_data  <= '0;
      r_toggle   <= '0;
      r_retry    <= '0;
      r_good     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_status   <= ST_OK;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= w_rd_pulse;
      // clear takes effect before a same-cycle start reaches DATA_TX
      if (r_state == IDLE && toggle_clr) begin
        r_toggle <= '0;
      end else if (w_flip) begin
        r_toggle[w_tidx] <= ~r_toggle[w_tidx];
      end
      if (w_capture) begin
        r_dir     <= xact_dir;
        r_addr    <= addr;
        r_endp    <= endp;
        r_wr_data <= wr_data;
        r_retry   <= '0;
        r_status  <= ST_OK;
      end
      if (w_set_status) r_status <= w_status_val;
      if (w_retry_inc)  r_retry  <= r_retry + RW'(1);
      if (w_mark)       r_good   <= w_mark_val;
      if (w_latch_rd)   r_rd_data <= rx_data;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign done     = (r_state == DONE);
  assign status   = r_status;
  assign busy     = (r_state != IDLE);
  assign rx_en    = w_wait;

endmodule

// File: tb/tb_usb_xact_engine.sv
// tb/tb_usb_xact_engine.sv - directed self-checking bench for usb_xact_engine.
module tb_usb_xact_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, xact_dir, toggle_clr;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] wr_data, rd_data, tx_data, rx_data;
  logic        rd_valid, done, busy, tx_valid, tx_ready, rx_valid, rx_corrupt, rx_en;
  logic [1:0]  status;
  logic [7:0]  tx_pid, rx_pid;
  logic [6:0]  tx_addr;
  logic [3:0]  tx_endp;

  always #5 clk = ~clk;

  usb_xact_engine dut (
    .clk(clk), .rst(rst), .start(start), .xact_dir(xact_dir), .addr(addr), .endp(endp),
    .wr_data(wr_data), .toggle_clr(toggle_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .status(status), .busy(busy), .tx_pid(tx_pid), .tx_addr(tx_addr),
    .tx_endp(tx_endp), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_pid(rx_pid), .rx_data(rx_data), .rx_valid(rx_valid), .rx_corrupt(rx_corrupt),
    .rx_en(rx_en)
  );

  logic [7:0]  pid_q[$];
  logic [6:0]  addr_q[$];
  logic [3:0]  endp_q[$];
  logic [63:0] data_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt = 0;
  int          rdv_cnt  = 0;
  logic [63:0] rdv_val  = '0;
  int          done_base, rdv_base;
  int          n_checks = 0;
  int          n_pass   = 0;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      pid_q.push_back(tx_pid);
      addr_q.push_back(tx_addr);
      endp_q.push_back(tx_endp);
      data_q.push_back(tx_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rd_valid) begin
      rdv_cnt <= rdv_cnt + 1;
      rdv_val <= rd_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic expired_wait(input string tag);
    n_checks++;
    $display("FAIL %s: wait budget expired", tag);
  endtask

  task automatic start_xact(input logic dir, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d, input logic clr);
    @(negedge clk);
    pid_q.delete(); addr_q.delete(); endp_q.delete(); data_q.delete();
    done_base = done_cnt;
    rdv_base  = rdv_cnt;
    xact_dir = dir; addr = a; endp = e; wr_data = d; toggle_clr = clr; start = 1'b1;
    @(negedge clk);
    start = 1'b0; toggle_clr = 1'b0;
  endtask

  task automatic wait_rx_en(input string tag);
    int n = 0;
    while (!rx_en && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_en) expired_wait(tag);
  endtask

  task automatic send_rx(input logic [7:0] p, input logic [63:0] d, input logic c);
    rx_pid = p; rx_data = d; rx_corrupt = c; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_corrupt = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == done_base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == done_base) expired_wait(tag);
  endtask

  task automatic compare_pids(input string tag);
    check({tag, "_npkt"}, 64'(pid_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < pid_q.size(); i++)
      check($sformatf("%s_pid%0d", tag, i), 64'(pid_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; xact_dir = 1'b0; toggle_clr = 1'b0; addr = '0; endp = '0;
    wr_data = '0; tx_ready = 1'b1; rx_pid = '0; rx_data = '0; rx_valid = 1'b0; rx_corrupt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_pid", 64'(tx_pid), 64'd0);
    check("rst_rx_en", 64'(rx_en), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);

    // OUT acked, with a stray start while busy
    start_xact(1'b0, 7'h05, 4'd1, 64'h1122334455667788, 1'b0);
    wait_rx_en("t1_hs");
    xact_dir = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_rx(8'hD2, 64'd0, 1'b0);
    wait_done("t1_done");
    exp_q = '{8'hE1, 8'hC3};
    compare_pids("t1");
    check("t1_addr", 64'(addr_q[0]), 64'h05);
    check("t1_endp", 64'(endp_q[0]), 64'd1);
    check("t1_data", data_q[1], 64'h1122334455667788);
    check("t1_status", 64'(status), 64'd0);
    check("t1_ndone", 64'(done_cnt - done_base), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);

    // second OUT on endp 1 uses DATA1; encoder holds off for three cycles
    tx_ready = 1'b0;
    start_xact(1'b0, 7'h05, 4'd1, 64'hA5A5A5A5A5A5A5A5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_hold_valid%0d", i), 64'(tx_valid), 64'd1);
      check($sformatf("t2_hold_pid%0d", i), 64'(tx_pid), 64'hE1);
      @(negedge clk);
    end
    check("t2_hold_npkt", 64'(pid_q.size()), 64'd0);
    tx_ready = 1'b1;
    wait_rx_en("t2_hs");
    send_rx(8'hD2, 64'd0, 1'b0);
    wait_done("t2_done");
    exp_q = '{8'hE1, 8'h4B};
    compare_pids("t2");
    check("t2_data", data_q[1], 64'hA5A5A5A5A5A5A5A5);

    // IN endp 2, DATA0 delivered
    start_xact(1'b1, 7'h05, 4'd2, 64'd0, 1'b0);
    wait_rx_en("t3_data");
    send_rx(8'hC3, 64'hDEADBEEF00000000, 1'b0);
    wait_done("t3_done");
    exp_q = '{8'h69, 8'hD2};
    compare_pids("t3");
    check("t3_nrdv", 64'(rdv_cnt - rdv_base), 64'd1);
    check("t3_rdata", rdv_val, 64'hDEADBEEF00000000);
    check("t3_status", 64'(status), 64'd0);

    // OUT endp 3 NAKed on every attempt: 1 + 3 retries
    start_xact(1'b0, 7'h05, 4'd3, 64'h0123456789ABCDEF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_rx_en("t4_hs");
      send_rx(8'h5A, 64'd0, 1'b0);
    end
    wait_done("t4_done");
    exp_q = '{8'hE1, 8'hC3, 8'hE1, 8'hC3, 8'hE1, 8'hC3, 8'hE1, 8'hC3};
    compare_pids("t4");
    check("t4_status", 64'(status), 64'd1);
    check("t4_ndone", 64'(done_cnt - done_base), 64'd1);

    // toggle of endp 3 was not flipped by the failed transaction
    start_xact(1'b0, 7'h05, 4'd3, 64'h55, 1'b0);
    wait_rx_en("t5_hs");
    send_rx(8'hD2, 64'd0, 1'b0);
    wait_done("t5_done");
    exp_q = '{8'hE1, 8'hC3};
    compare_pids("t5");
    check("t5_status", 64'(status), 64'd0);

    // IN endp 4: silent device times out, corrupt DATA0 not acked, good DATA0 delivered
    start_xact(1'b1, 7'h11, 4'd4, 64'd0, 1'b0);
    wait_rx_en("t6_data1");
    begin
      int n = 0;
      while (rx_en && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("t6_wait_cycles", 64'(n), 64'd256);
    end
    wait_rx_en("t6_data2");
    send_rx(8'hC3, 64'h0102030405060708, 1'b1);
    wait_rx_en("t6_data3");
    send_rx(8'hC3, 64'hCAFEF00D12345678, 1'b0);
    wait_done("t6_done");
    exp_q = '{8'h69, 8'h69, 8'h69, 8'hD2};
    compare_pids("t6");
    check("t6_addr", 64'(addr_q[0]), 64'h11);
    check("t6_nrdv", 64'(rdv_cnt - rdv_base), 64'd1);
    check("t6_rdata", rdv_val, 64'hCAFEF00D12345678);
    check("t6_status", 64'(status), 64'd0);

    // IN endp 2 after lost ACK: repeated DATA0 acked and dropped, DATA1 delivered
    start_xact(1'b1, 7'h05, 4'd2, 64'd0, 1'b0);
    wait_rx_en("t7_data1");
    send_rx(8'hC3, 64'h1111111111111111, 1'b0);
    wait_rx_en("t7_data2");
    send_rx(8'h4B, 64'h2222222222222222, 1'b0);
    wait_done("t7_done");
    exp_q = '{8'h69, 8'hD2, 8'h69, 8'hD2};
    compare_pids("t7");
    check("t7_nrdv", 64'(rdv_cnt - rdv_base), 64'd1);
    check("t7_rdata", rdv_val, 64'h2222222222222222);
    check("t7_status", 64'(status), 64'd0);

    // toggle_clr with start: endp 3 (toggle 1) restarts at DATA0
    start_xact(1'b0, 7'h05, 4'd3, 64'h77, 1'b1);
    wait_rx_en("t8_hs");
    send_rx(8'hD2, 64'd0, 1'b0);
    wait_done("t8_done");
    exp_q = '{8'hE1, 8'hC3};
    compare_pids("t8");

    // STALL ends the transaction at once
    start_xact(1'b0, 7'h05, 4'd5, 64'h99, 1'b0);
    wait_rx_en("t9_hs");
    send_rx(8'h1E, 64'd0, 1'b0);
    wait_done("t9_done");
    exp_q = '{8'hE1, 8'hC3};
    compare_pids("t9");
    check("t9_status", 64'(status), 64'd2);

    // reset mid-transaction: no done, all toggles cleared
    start_xact(1'b0, 7'h05, 4'd6, 64'h66, 1'b0);
    wait_rx_en("t10_hs");
    done_base = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t10_busy", 64'(busy), 64'd0);
    check("t10_tx_valid", 64'(tx_valid), 64'd0);
    check("t10_rx_en", 64'(rx_en), 64'd0);
    check("t10_status", 64'(status), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t10_ndone", 64'(done_cnt - done_base), 64'd0);
    start_xact(1'b0, 7'h05, 4'd3, 64'h88, 1'b0);
    wait_rx_en("t11_hs");
    send_rx(8'hD2, 64'd0, 1'b0);
    wait_done("t11_done");
    exp_q = '{8'hE1, 8'hC3};
    compare_pids("t11");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
